// File: rtl/escape_rgb_mapper.sv
// Maps a Mandelbrot escape count to an R/G/B triple using three
// serial shift-add multipliers and a start/done/ack handshake.
module escape_rgb_mapper #(
    parameter int ESC_W     = 10,
    parameter int COEFF_W   = 8,
    parameter int FRAC_BITS = 4,
    parameter int COLOR_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ESC_W-1:0]   escape,
    input  logic [ESC_W-1:0]   max_iter,
    input  logic [1:0]         mode,
    input  logic [COEFF_W-1:0] coeff_r,
    input  logic [COEFF_W-1:0] coeff_g,
    input  logic [COEFF_W-1:0] coeff_b,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               busy,
    output logic               done,
    input  logic               ack
);

    localparam int ACC_W = ESC_W + COEFF_W;
    localparam int CNT_W = $clog2(ESC_W + 1);
    localparam logic [ACC_W-1:0] CMAX = ACC_W'((1 << COLOR_W) - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ESC_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, RESULT, DONE} state_t;

    state_t             state_q, state_d;
    logic [ESC_W-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   mcand_q [3];
    logic [ACC_W-1:0]   mcand_d [3];
    logic [ACC_W-1:0]   acc_q [3];
    logic [ACC_W-1:0]   acc_d [3];
    logic [COLOR_W-1:0] rgb_q [3];
    logic [COLOR_W-1:0] rgb_d [3];
    logic [CNT_W-1:0]   step_q, step_d;
    logic               inset_q, inset_d;
    logic               band_q, band_d;
    logic               done_q, done_d;
    logic               perch;

    // Band mode wraps; every other mode clamps to full intensity.
    function automatic logic [COLOR_W-1:0] map_chan(
        input logic [ACC_W-1:0] acc,
        input logic             band
    );
        logic [ACC_W-1:0] s;
        s = acc >> FRAC_BITS;
        if (!band && s > CMAX) map_chan = '1;
        else                   map_chan = s[COLOR_W-1:0];
    endfunction

    assign perch = mode[0] ^ mode[1];

    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        step_d   = step_q;
        inset_d  = inset_q;
        band_d   = band_q;
        done_d   = done_q;
        for (int i = 0; i < 3; i++) begin
            mcand_d[i] = mcand_q[i];
            acc_d[i]   = acc_q[i];
            rgb_d[i]   = rgb_q[i];
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mplier_d   = escape;
                    mcand_d[0] = ACC_W'(coeff_r);
                    mcand_d[1] = ACC_W'(perch ? coeff_g : coeff_r);
                    mcand_d[2] = ACC_W'(perch ? coeff_b : coeff_r);
                    for (int i = 0; i < 3; i++) acc_d[i] = '0;
                    step_d  = '0;
                    band_d  = (mode == 2'b10);
                    inset_d = (escape >= max_iter);
                    state_d = (escape >= max_iter) ? RESULT : MUL;
                end
            end
            MUL: begin
                for (int i = 0; i < 3; i++) begin
                    if (mplier_q[0]) acc_d[i] = acc_q[i] + mcand_q[i];
                    mcand_d[i] = mcand_q[i] << 1;
                end
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 1'b1;
                if (step_q == LAST) state_d = RESULT;
            end
            RESULT: begin
                for (int i = 0; i < 3; i++)
                    rgb_d[i] = inset_q ? '0 : map_chan(acc_q[i], band_q);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (ack) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            step_q   <= '0;
            inset_q  <= 1'b0;
            band_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                mcand_q[i] <= '0;
                acc_q[i]   <= '0;
                rgb_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            step_q   <= step_d;
            inset_q  <= inset_d;
            band_q   <= band_d;
            done_q   <= done_d;
            for (int i = 0; i < 3; i++) begin
                mcand_q[i] <= mcand_d[i];
                acc_q[i]   <= acc_d[i];
                rgb_q[i]   <= rgb_d[i];
            end
        end
    end

    assign red   = rgb_q[0];
    assign green = rgb_q[1];
    assign blue  = rgb_q[2];
    assign done  = done_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_escape_rgb_mapper.sv
// Directed bench for escape_rgb_mapper: vector table plus
// hand-written handshake, abuse and reset sequences.
module tb_escape_rgb_mapper;

    logic       clk = 1'b0;
    logic       reset, start, ack;
    logic [9:0] escape, max_iter;
    logic [1:0] mode;
    logic [7:0] coeff_r, coeff_g, coeff_b;
    logic [7:0] red, green, blue;
    logic       busy, done;

    int tests = 0;
    int fails = 0;

    escape_rgb_mapper dut (
        .clk(clk), .reset(reset), .start(start),
        .escape(escape), .max_iter(max_iter), .mode(mode),
        .coeff_r(coeff_r), .coeff_g(coeff_g), .coeff_b(coeff_b),
        .red(red), .green(green), .blue(blue),
        .busy(busy), .done(done), .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] esc;
        logic [9:0] mi;
        logic [1:0] md;
        logic [7:0] cr, cg, cb;
        logic [7:0] er, eg, eb;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(
        input logic [9:0] esc, input logic [9:0] mi,
        input logic [1:0] md, input logic [7:0] cr,
        input logic [7:0] cg, input logic [7:0] cb,
        input logic [7:0] er, input logic [7:0] eg,
        input logic [7:0] eb, input int lat);
        vec_t v;
        v.esc = esc; v.mi = mi; v.md = md;
        v.cr = cr; v.cg = cg; v.cb = cb;
        v.er = er; v.eg = eg; v.eb = eb; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        escape = v.esc; max_iter = v.mi; mode = v.md;
        coeff_r = v.cr; coeff_g = v.cg; coeff_b = v.cb;
    endtask

    // After the start edge: count edges until done, noting busy drops.
    task automatic wait_done(output int lat, output int busy_bad);
        lat = 0;
        busy_bad = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic check_rgb(input string name, input vec_t v);
        check({name, ".r"}, red, v.er);
        check({name, ".g"}, green, v.eg);
        check({name, ".b"}, blue, v.eb);
    endtask

    initial begin
        int   lat, bb;
        vec_t v;
        logic [7:0] hr, hg, hb;

        vecs[0]  = mk(3, 255, 2'b00, 8'h40, 8'h00, 8'h00, 12, 12, 12, 11);
        vecs[1]  = mk(5, 255, 2'b01, 8'h10, 8'h20, 8'h30, 5, 10, 15, 11);
        vecs[2]  = mk(100, 255, 2'b01, 8'hFF, 8'hFF, 8'hFF, 255, 255, 255, 11);
        vecs[3]  = mk(100, 255, 2'b10, 8'hFF, 8'hFF, 8'hFF, 57, 57, 57, 11);
        vecs[4]  = mk(255, 255, 2'b00, 8'h40, 8'h40, 8'h40, 0, 0, 0, 1);
        vecs[5]  = mk(300, 255, 2'b01, 8'h40, 8'h40, 8'h40, 0, 0, 0, 1);
        vecs[6]  = mk(12, 255, 2'b00, 8'h10, 8'hFF, 8'hFF, 12, 12, 12, 11);
        vecs[7]  = mk(3, 255, 2'b11, 8'h40, 8'hFF, 8'h01, 12, 12, 12, 11);
        vecs[8]  = mk(0, 255, 2'b01, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 11);
        vecs[9]  = mk(0, 0, 2'b00, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 1);
        vecs[10] = mk(1022, 1023, 2'b10, 8'hFF, 8'h01, 8'h80, 160, 63, 240, 11);

        reset = 1'b1; start = 1'b0; ack = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.rgb", {red, green, blue}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            launch(vecs[i]);
            wait_done(lat, bb);
            check($sformatf("v%0d.lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d.busy", i), bb, 0);
            check_rgb($sformatf("v%0d", i), vecs[i]);
            do_ack();
            check($sformatf("v%0d.ackdone", i), done, 0);
        end

        // Outputs and done held while ack stays low.
        launch(vecs[1]);
        wait_done(lat, bb);
        bb = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!done || red != 5 || green != 10 || blue != 15) bb++;
        end
        check("hold.stable", bb, 0);
        do_ack();
        check("hold.done", done, 0);
        check("hold.busy", busy, 0);
        check_rgb("hold.keep", vecs[1]);

        // ack in IDLE ignored.
        do_ack();
        check("idleack.busy", busy, 0);

        // Abuse during MUL: start/ack pulses, escape changed.
        launch(vecs[1]);
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; ack = 1'b1; escape = 100;
        coeff_r = 8'hFF; mode = 2'b10;
        @(posedge clk); #1;
        start = 1'b0; ack = 1'b0;
        lat = 2;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("abuse.lat", lat, 11);
        check_rgb("abuse", vecs[1]);

        // start and ack together in DONE: back to IDLE only.
        @(negedge clk);
        start = 1'b1; ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ack = 1'b0;
        check("both.done", done, 0);
        check("both.busy", busy, 0);
        bb = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy) bb++;
        end
        check("both.nojob", bb, 0);

        // Reset mid-MUL, start held through the reset.
        launch(vecs[2]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        v = vecs[0];
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        check("mrst.busy", busy, 0);
        check("mrst.done", done, 0);
        check("mrst.rgb", {red, green, blue}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        hr = red; hg = green; hb = blue;
        check("mrst.e0busy", busy, 1);
        wait_done(lat, bb);
        check("mrst.lat", lat, 11);
        check_rgb("mrst", v);
        check("mrst.pre", {hr, hg, hb}, 0);
        do_ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
